// File: rtl/eth_e2e_afu_csr.sv
// rtl/eth_e2e_afu_csr.sv - MMIO CSR front end with indirect PRMG window to the E2E register file and MAC CSR bridge.
// Optional link status/drop counter (E2E regs 9/10) enabled by defining E2E_LINK_STAT_EN.
module eth_e2e_afu_csr #(
  parameter logic [63:0] AFU_ID_L  = 64'h0,
  parameter logic [63:0] AFU_ID_H  = 64'h0,
  parameter int          NUM_PORTS = 4
) (
  input  logic                 pClk,
  input  logic                 pck_cp2af_softReset,
  input  logic                 mmio_rd_valid,
  input  logic                 mmio_wr_valid,
  input  logic [15:0]          mmio_addr,
  input  logic [8:0]           mmio_tid,
  input  logic [63:0]          mmio_wdata,
  output logic                 mmio_rsp_valid,
  output logic [8:0]           mmio_rsp_tid,
  output logic [63:0]          mmio_rsp_data,
  output logic [15:0]          mac_csr_addr,
  output logic [31:0]          mac_csr_wdata,
  output logic                 mac_csr_wr,
  output logic                 mac_csr_rd,
  input  logic [31:0]          mac_csr_rdata,
  input  logic                 mac_csr_waitrequest,
  output logic [1:0]           mac_port_sel,
  output logic [NUM_PORTS-1:0] mac_rst,
  output logic [NUM_PORTS-1:0] loop_en,
  input  logic [NUM_PORTS-1:0] freq_lock,
  input  logic [NUM_PORTS-1:0] word_lock,
  input  logic [NUM_PORTS-1:0] tx_ready,
  input  logic [NUM_PORTS-1:0] rx_ready
);

  localparam logic [63:0] DFH = 64'h1000_0000_0000_1001;

  typedef enum logic [1:0] {E10_IDLE, E10_WR, E10_RD} e10_state_t;

  logic        rst;
  logic [14:0] mmio_idx;
  assign rst      = pck_cp2af_softReset;
  assign mmio_idx = mmio_addr[15:1];

  // Host-visible registers
  logic [63:0] scratch, prmg_ctrl, prmg_wdata, prmg_rdata;
  logic        prmg_wr_go, prmg_rd_go;
  logic [15:0] prmg_addr;

  // Read pipeline: stage 1 captures the request, stage 2 registers the response
  logic        rd_s1_valid;
  logic [8:0]  rd_s1_tid;
  logic [14:0] rd_s1_idx;
  logic [63:0] mmio_rd_mux;

  // E2E register file
  logic [31:0]          e2e_scratch, e10_wdata, e10_rdata, e2e_rdata;
  logic [17:0]          e10_ctrl;
  e10_state_t           e10_state;
  logic                 e10_busy;
  logic [NUM_PORTS-1:0] freq_meta, freq_sync, word_meta, word_sync;
  logic [NUM_PORTS-1:0] tx_meta, tx_sync, rx_meta, rx_sync;

  assign e10_busy      = (e10_state != E10_IDLE);
  assign mac_csr_addr  = e10_ctrl[15:0];
  assign mac_csr_wdata = e10_wdata;

  always_comb begin
    mmio_rd_mux = 64'h0;
    case (rd_s1_idx)
      15'd0:   mmio_rd_mux = DFH;
      15'd1:   mmio_rd_mux = AFU_ID_L;
      15'd2:   mmio_rd_mux = AFU_ID_H;
      15'd6:   mmio_rd_mux = prmg_ctrl;
      15'd7:   mmio_rd_mux = prmg_wdata;
      15'd8:   mmio_rd_mux = prmg_rdata;
      15'd9:   mmio_rd_mux = scratch;
      default: mmio_rd_mux = 64'h0;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (rst) begin
      rd_s1_valid    <= 1'b0;
      rd_s1_tid      <= 9'h0;
      rd_s1_idx      <= 15'h0;
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_tid   <= 9'h0;
      mmio_rsp_data  <= 64'h0;
    end else begin
      rd_s1_valid    <= mmio_rd_valid;
      rd_s1_tid      <= mmio_tid;
      rd_s1_idx      <= mmio_idx;
      mmio_rsp_valid <= rd_s1_valid;
      if (rd_s1_valid) begin
        mmio_rsp_tid  <= rd_s1_tid;
        mmio_rsp_data <= mmio_rd_mux;
      end
    end
  end

  // Commands fire on a 0->1 transition of the wr/rd bits against the stored control value
  always_ff @(posedge pClk) begin
    if (rst) begin
      scratch    <= 64'h0;
      prmg_ctrl  <= 64'h0;
      prmg_wdata <= 64'h0;
      prmg_rdata <= 64'h0;
      prmg_wr_go <= 1'b0;
      prmg_rd_go <= 1'b0;
      prmg_addr  <= 16'h0;
    end else begin
      prmg_wr_go <= 1'b0;
      prmg_rd_go <= 1'b0;
      if (mmio_wr_valid) begin
        case (mmio_idx)
          15'd6: begin
            prmg_ctrl  <= mmio_wdata;
            prmg_addr  <= mmio_wdata[15:0];
            prmg_wr_go <= mmio_wdata[16] && !prmg_ctrl[16];
            prmg_rd_go <= mmio_wdata[17] && !prmg_ctrl[17] &&
                          !(mmio_wdata[16] && !prmg_ctrl[16]);
          end
          15'd7:   prmg_wdata <= mmio_wdata;
          15'd9:   scratch    <= mmio_wdata;
          default: ;
        endcase
      end
      if (prmg_rd_go)
        prmg_rdata <= {32'h0, e2e_rdata};
    end
  end

  always_ff @(posedge pClk) begin
    if (rst) begin
      freq_meta <= '0; freq_sync <= '0;
      word_meta <= '0; word_sync <= '0;
      tx_meta   <= '0; tx_sync   <= '0;
      rx_meta   <= '0; rx_sync   <= '0;
    end else begin
      freq_meta <= freq_lock; freq_sync <= freq_meta;
      word_meta <= word_lock; word_sync <= word_meta;
      tx_meta   <= tx_ready;  tx_sync   <= tx_meta;
      rx_meta   <= rx_ready;  rx_sync   <= rx_meta;
    end
  end

`ifdef E2E_LINK_STAT_EN
  logic [NUM_PORTS-1:0] link_prev, link_fall;
  logic [31:0]          link_drop_cnt;
  logic [32:0]          link_drop_sum;
  assign link_fall     = link_prev & ~(tx_sync | rx_sync);
  assign link_drop_sum = {1'b0, link_drop_cnt} + 33'($countones(link_fall));

  always_ff @(posedge pClk) begin
    if (rst) begin
      link_prev     <= '0;
      link_drop_cnt <= 32'h0;
    end else begin
      link_prev <= tx_sync | rx_sync;
      if (prmg_wr_go && prmg_addr == 16'd10)
        link_drop_cnt <= 32'h0;
      else if (link_drop_sum[32])
        link_drop_cnt <= 32'hFFFF_FFFF;
      else
        link_drop_cnt <= link_drop_sum[31:0];
    end
  end
`else
  logic unused_link;
  assign unused_link = &{1'b0, tx_sync, rx_sync};
`endif

  always_comb begin
    e2e_rdata = 32'h0;
    case (prmg_addr)
      16'd0:   e2e_rdata = e2e_scratch;
      16'd1:   e2e_rdata = 32'(mac_rst);
      16'd2:   e2e_rdata = {e10_busy, 13'h0, e10_ctrl};
      16'd3:   e2e_rdata = e10_wdata;
      16'd4:   e2e_rdata = e10_rdata;
      16'd5:   e2e_rdata = {30'h0, mac_port_sel};
      16'd6:   e2e_rdata = 32'(loop_en);
      16'd7:   e2e_rdata = 32'(freq_sync);
      16'd8:   e2e_rdata = 32'(word_sync);
`ifdef E2E_LINK_STAT_EN
      16'd9:   e2e_rdata = 32'({rx_sync, tx_sync});
      16'd10:  e2e_rdata = link_drop_cnt;
`endif
      default: e2e_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (rst) begin
      e2e_scratch  <= 32'h0;
      mac_rst      <= '1;
      e10_ctrl     <= 18'h0;
      e10_wdata    <= 32'h0;
      e10_rdata    <= 32'h0;
      mac_port_sel <= 2'h0;
      loop_en      <= '0;
      e10_state    <= E10_IDLE;
      mac_csr_wr   <= 1'b0;
      mac_csr_rd   <= 1'b0;
    end else begin
      if (prmg_wr_go) begin
        case (prmg_addr)
          16'd0:   e2e_scratch  <= prmg_wdata[31:0];
          16'd1:   mac_rst      <= prmg_wdata[NUM_PORTS-1:0];
          16'd3:   e10_wdata    <= prmg_wdata[31:0];
          16'd5:   mac_port_sel <= prmg_wdata[1:0];
          16'd6:   loop_en      <= prmg_wdata[NUM_PORTS-1:0];
          default: ;
        endcase
      end
      case (e10_state)
        E10_IDLE: begin
          if (prmg_wr_go && prmg_addr == 16'd2) begin
            e10_ctrl <= prmg_wdata[17:0];
            if (prmg_wdata[16]) begin
              e10_state  <= E10_WR;
              mac_csr_wr <= 1'b1;
            end else if (prmg_wdata[17]) begin
              e10_state  <= E10_RD;
              mac_csr_rd <= 1'b1;
            end
          end
        end
        E10_WR: begin
          if (!mac_csr_waitrequest) begin
            e10_state  <= E10_IDLE;
            mac_csr_wr <= 1'b0;
          end
        end
        E10_RD: begin
          if (!mac_csr_waitrequest) begin
            e10_rdata  <= mac_csr_rdata;
            e10_state  <= E10_IDLE;
            mac_csr_rd <= 1'b0;
          end
        end
        default: begin
          e10_state  <= E10_IDLE;
          mac_csr_wr <= 1'b0;
          mac_csr_rd <= 1'b0;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, mmio_addr[0]};

endmodule

// File: tb/tb_eth_e2e_afu_csr.sv
// tb/tb_eth_e2e_afu_csr.sv - directed self-checking bench for eth_e2e_afu_csr.
module tb_eth_e2e_afu_csr;

  localparam logic [63:0] ID_L = 64'h1111_2222_3333_4444;
  localparam logic [63:0] ID_H = 64'h5555_6666_7777_8888;

  logic        pClk = 1'b0;
  logic        pck_cp2af_softReset;
  logic        mmio_rd_valid, mmio_wr_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        mmio_rsp_valid;
  logic [8:0]  mmio_rsp_tid;
  logic [63:0] mmio_rsp_data;
  logic [15:0] mac_csr_addr;
  logic [31:0] mac_csr_wdata;
  logic        mac_csr_wr, mac_csr_rd;
  logic [31:0] mac_csr_rdata;
  logic        mac_csr_waitrequest;
  logic [1:0]  mac_port_sel;
  logic [3:0]  mac_rst, loop_en, freq_lock, word_lock, tx_ready, rx_ready;

  int total = 0;
  int bad = 0;

  eth_e2e_afu_csr #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .NUM_PORTS(4)) dut (
    .pClk(pClk), .pck_cp2af_softReset(pck_cp2af_softReset),
    .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid), .mmio_rsp_data(mmio_rsp_data),
    .mac_csr_addr(mac_csr_addr), .mac_csr_wdata(mac_csr_wdata),
    .mac_csr_wr(mac_csr_wr), .mac_csr_rd(mac_csr_rd),
    .mac_csr_rdata(mac_csr_rdata), .mac_csr_waitrequest(mac_csr_waitrequest),
    .mac_port_sel(mac_port_sel), .mac_rst(mac_rst), .loop_en(loop_en),
    .freq_lock(freq_lock), .word_lock(word_lock), .tx_ready(tx_ready), .rx_ready(rx_ready)
  );

  always #5 pClk = ~pClk;

  task automatic step();
    @(posedge pClk);
    #1;
  endtask

  task automatic mmio_wr(input logic [14:0] idx, input logic [63:0] data);
    mmio_wr_valid = 1'b1;
    mmio_addr     = {idx, 1'b0};
    mmio_wdata    = data;
    step();
    mmio_wr_valid = 1'b0;
  endtask

  // Issues one read; lat_ok is set only if the response appears exactly two cycles later
  task automatic mmio_rd(input logic [14:0] idx, input logic [8:0] tid,
                         output logic [63:0] data, output logic [8:0] rtid, output logic lat_ok);
    mmio_rd_valid = 1'b1;
    mmio_addr     = {idx, 1'b0};
    mmio_tid      = tid;
    step();
    mmio_rd_valid = 1'b0;
    lat_ok = !mmio_rsp_valid;
    step();
    lat_ok = lat_ok && mmio_rsp_valid;
    data   = mmio_rsp_data;
    rtid   = mmio_rsp_tid;
  endtask

  task automatic prmg_wr(input logic [15:0] addr, input logic [31:0] data);
    mmio_wr(15'd7, {32'h0, data});
    mmio_wr(15'd6, {46'h0, 2'b01, addr});
    mmio_wr(15'd6, {48'h0, addr});
  endtask

  task automatic prmg_rd(input logic [15:0] addr, output logic [63:0] data);
    logic [8:0] t;
    logic       l;
    mmio_wr(15'd6, {46'h0, 2'b10, addr});
    mmio_wr(15'd6, {48'h0, addr});
    mmio_rd(15'd8, 9'h0, data, t, l);
  endtask

  task automatic test_reset();
    logic [63:0] d;
    logic [8:0]  t;
    logic        l;
    total++; if (mmio_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", mmio_rsp_valid); end
    total++; if (mmio_rsp_data !== 64'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", mmio_rsp_data); end
    total++; if ({mac_csr_wr, mac_csr_rd} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {mac_csr_wr, mac_csr_rd}); end
    total++; if (mac_rst !== 4'hF) begin bad++; $display("FAIL reset_mac_rst got=%h exp=f", mac_rst); end
    total++; if (loop_en !== 4'h0) begin bad++; $display("FAIL reset_loop_en got=%h exp=0", loop_en); end
    total++; if (mac_port_sel !== 2'h0) begin bad++; $display("FAIL reset_port_sel got=%h exp=0", mac_port_sel); end
    mmio_rd(15'd0, 9'h11, d, t, l);
    total++; if (d !== 64'h1000_0000_0000_1001) begin bad++; $display("FAIL dfh got=%h exp=1000000000001001", d); end
    mmio_rd(15'd1, 9'h12, d, t, l);
    total++; if (d !== ID_L) begin bad++; $display("FAIL afu_id_l got=%h exp=%h", d, ID_L); end
    mmio_rd(15'd2, 9'h13, d, t, l);
    total++; if (d !== ID_H) begin bad++; $display("FAIL afu_id_h got=%h exp=%h", d, ID_H); end
    mmio_rd(15'd9, 9'h14, d, t, l);
    total++; if (d !== 64'h0) begin bad++; $display("FAIL reset_scratch got=%h exp=0", d); end
  endtask

  task automatic test_scratch();
    logic [63:0] d;
    logic [8:0]  t;
    logic        l;
    mmio_wr(15'd9, 64'hdeef_d00f_d11f_daaf);
    mmio_rd(15'd9, 9'h1A5, d, t, l);
    total++; if (d !== 64'hdeef_d00f_d11f_daaf) begin bad++; $display("FAIL scratch_data got=%h exp=deefd00fd11fdaaf", d); end
    total++; if (t !== 9'h1A5) begin bad++; $display("FAIL scratch_tid got=%h exp=1a5", t); end
    total++; if (l !== 1'b1) begin bad++; $display("FAIL scratch_latency got=%b exp=1", l); end
    mmio_wr(15'd3, 64'h1234);
    mmio_rd(15'd3, 9'h2, d, t, l);
    total++; if (d !== 64'h0) begin bad++; $display("FAIL unmapped_idx got=%h exp=0", d); end
  endtask

  task automatic test_back_to_back();
    mmio_rd_valid = 1'b1; mmio_addr = {15'd9, 1'b0}; mmio_tid = 9'h5;
    step();
    mmio_addr = {15'd0, 1'b0}; mmio_tid = 9'h6;
    step();
    mmio_rd_valid = 1'b0;
    total++; if ({mmio_rsp_valid, mmio_rsp_tid} !== {1'b1, 9'h5} || mmio_rsp_data !== 64'hdeef_d00f_d11f_daaf) begin
      bad++; $display("FAIL b2b_first got=%b/%h/%h exp=1/005/deefd00fd11fdaaf", mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data); end
    step();
    total++; if ({mmio_rsp_valid, mmio_rsp_tid} !== {1'b1, 9'h6} || mmio_rsp_data !== 64'h1000_0000_0000_1001) begin
      bad++; $display("FAIL b2b_second got=%b/%h/%h exp=1/006/1000000000001001", mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data); end
    step();
    total++; if (mmio_rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_single_pulse got=%b exp=0", mmio_rsp_valid); end
  endtask

  task automatic test_prmg();
    logic [63:0] d;
    logic [8:0]  t;
    logic        l;
    prmg_wr(16'd0, 32'hDAEF_CAFE);
    prmg_rd(16'd0, d);
    total++; if (d !== 64'h0000_0000_DAEF_CAFE) begin bad++; $display("FAIL prmg_e2e0 got=%h exp=00000000daefcafe", d); end
    mmio_wr(15'd7, 64'h55);
    mmio_wr(15'd6, 64'h30000);
    mmio_wr(15'd6, 64'h0);
    mmio_rd(15'd8, 9'h0, d, t, l);
    total++; if (d !== 64'h0000_0000_DAEF_CAFE) begin bad++; $display("FAIL prmg_both_no_rd got=%h exp=00000000daefcafe", d); end
    prmg_rd(16'd0, d);
    total++; if (d !== 64'h55) begin bad++; $display("FAIL prmg_both_wr got=%h exp=55", d); end
    prmg_rd(16'd7, d);
    total++; if (d !== 64'h5) begin bad++; $display("FAIL freq_lock got=%h exp=5", d); end
    prmg_rd(16'd8, d);
    total++; if (d !== 64'hA) begin bad++; $display("FAIL word_lock got=%h exp=a", d); end
    prmg_rd(16'd12, d);
    total++; if (d !== 64'h0) begin bad++; $display("FAIL e2e_unmapped got=%h exp=0", d); end
  endtask

  task automatic test_mac_ctrl();
    logic [63:0] d;
    prmg_wr(16'd1, 32'h0);
    prmg_wr(16'd6, 32'hF);
    total++; if (mac_rst !== 4'h0) begin bad++; $display("FAIL mac_rst_clear got=%h exp=0", mac_rst); end
    total++; if (loop_en !== 4'hF) begin bad++; $display("FAIL loop_en got=%h exp=f", loop_en); end
    prmg_rd(16'd6, d);
    total++; if (d !== 64'hF) begin bad++; $display("FAIL loop_en_rd got=%h exp=f", d); end
  endtask

  task automatic test_e10_wr();
    logic [63:0] d;
    mac_csr_waitrequest = 1'b1;
    prmg_wr(16'd5, 32'd2);
    prmg_wr(16'd3, 32'd10);
    prmg_wr(16'd2, 32'h13C00);
    total++; if ({mac_csr_addr, mac_csr_wdata, mac_port_sel} !== {16'h3C00, 32'd10, 2'd2}) begin
      bad++; $display("FAIL e10_wr_bus got=%h/%h/%h exp=3c00/0000000a/2", mac_csr_addr, mac_csr_wdata, mac_port_sel); end
    for (int i = 0; i < 3; i++) begin
      total++; if (mac_csr_wr !== 1'b1) begin bad++; $display("FAIL e10_wr_hold%0d got=%b exp=1", i, mac_csr_wr); end
      if (i < 2) step();
    end
    mac_csr_waitrequest = 1'b0;
    step();
    total++; if (mac_csr_wr !== 1'b0) begin bad++; $display("FAIL e10_wr_release got=%b exp=0", mac_csr_wr); end
    prmg_rd(16'd2, d);
    total++; if (d !== 64'h13C00) begin bad++; $display("FAIL e10_wr_ctrl got=%h exp=13c00", d); end
  endtask

  task automatic test_e10_rd();
    logic [63:0] d;
    mac_csr_rdata = 32'hA;
    prmg_wr(16'd2, 32'h21C02);
    total++; if ({mac_csr_rd, mac_csr_addr} !== {1'b1, 16'h1C02}) begin
      bad++; $display("FAIL e10_rd_start got=%b/%h exp=1/1c02", mac_csr_rd, mac_csr_addr); end
    step();
    total++; if (mac_csr_rd !== 1'b0) begin bad++; $display("FAIL e10_rd_release got=%b exp=0", mac_csr_rd); end
    mac_csr_rdata = 32'h0;
    prmg_rd(16'd4, d);
    total++; if (d !== 64'hA) begin bad++; $display("FAIL e10_rdata got=%h exp=a", d); end
    prmg_rd(16'd2, d);
    total++; if (d[31] !== 1'b0) begin bad++; $display("FAIL e10_busy_clear got=%b exp=0", d[31]); end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] d;
    mac_csr_waitrequest = 1'b1;
    prmg_wr(16'd2, 32'h10005);
    prmg_wr(16'd2, 32'h20007);
    total++; if ({mac_csr_wr, mac_csr_rd, mac_csr_addr} !== {2'b10, 16'h0005}) begin
      bad++; $display("FAIL busy_ignore got=%b%b/%h exp=10/0005", mac_csr_wr, mac_csr_rd, mac_csr_addr); end
    prmg_rd(16'd2, d);
    total++; if (d !== 64'h8001_0005) begin bad++; $display("FAIL busy_flag got=%h exp=80010005", d); end
    mac_csr_waitrequest = 1'b0;
    step();
    step();
    total++; if ({mac_csr_wr, mac_csr_rd} !== 2'b00) begin bad++; $display("FAIL busy_after got=%b exp=00", {mac_csr_wr, mac_csr_rd}); end
  endtask

  task automatic test_soft_reset();
    logic [63:0] d;
    logic [8:0]  t;
    logic        l;
    mmio_rd_valid = 1'b1; mmio_addr = {15'd9, 1'b0}; mmio_tid = 9'h7;
    step();
    mmio_rd_valid = 1'b0;
    pck_cp2af_softReset = 1'b1;
    step();
    pck_cp2af_softReset = 1'b0;
    total++; if (mmio_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_drop_rsp got=%b exp=0", mmio_rsp_valid); end
    mmio_wr(15'd9, 64'hABCD);
    mac_csr_waitrequest = 1'b1;
    prmg_wr(16'd2, 32'h20001);
    total++; if (mac_csr_rd !== 1'b1) begin bad++; $display("FAIL rst_rd_pending got=%b exp=1", mac_csr_rd); end
    pck_cp2af_softReset = 1'b1;
    step();
    pck_cp2af_softReset = 1'b0;
    mac_csr_waitrequest = 1'b0;
    total++; if (mac_csr_rd !== 1'b0) begin bad++; $display("FAIL rst_rd_drop got=%b exp=0", mac_csr_rd); end
    total++; if (mac_rst !== 4'hF) begin bad++; $display("FAIL rst_mac_rst got=%h exp=f", mac_rst); end
    mmio_rd(15'd9, 9'h8, d, t, l);
    total++; if (d !== 64'h0) begin bad++; $display("FAIL rst_scratch got=%h exp=0", d); end
    prmg_rd(16'd2, d);
    total++; if (d !== 64'h0) begin bad++; $display("FAIL rst_fsm_idle got=%h exp=0", d); end
  endtask

  initial begin
    pck_cp2af_softReset = 1'b1;
    mmio_rd_valid = 1'b0; mmio_wr_valid = 1'b0;
    mmio_addr = 16'h0; mmio_tid = 9'h0; mmio_wdata = 64'h0;
    mac_csr_rdata = 32'h0; mac_csr_waitrequest = 1'b0;
    freq_lock = 4'h5; word_lock = 4'hA; tx_ready = 4'hF; rx_ready = 4'hF;
    repeat (3) @(posedge pClk);
    #1;
    pck_cp2af_softReset = 1'b0;
    test_reset();
    test_scratch();
    test_back_to_back();
    test_prmg();
    test_mac_ctrl();
    test_e10_wr();
    test_e10_rd();
    test_busy_ignore();
    test_soft_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
